mpls_egress_demux: RTL and testbench

Egress distribution stage of the MPLS router, the counterpart of the ingress merge. Accepts packets from the single converged egress bus leaving the VNP4 core and steers each whole packet to one of NUM_EGR_PHYS_PORTS per-port AXIS outputs, selected by the destination port index carried in tuser on the first beat. Packets addressed to out-of-range or disabled ports are dropped and counted. Per-port width adaptation and clock crossing are done downstream and are outside this block.

---
 rtl/mpls_egress_demux.sv | 203 ++++++++++++++++++++
 tb/tb_mpls_egress_demux.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mpls_egress_demux.sv
// Egress demultiplexer: steers whole packets from the converged egress bus to
// one of NUM_EGR_PHYS_PORTS AXIS outputs, dropping packets to bad/disabled ports.
module mpls_egress_demux #(
    parameter int NUM_EGR_PHYS_PORTS = 4,
    parameter int DATA_BYTES         = 64,
    parameter int USER_WIDTH         = 8,
    parameter int ID_WIDTH           = 8,
    parameter int DEST_WIDTH         = 8,
    parameter int PORT_INDEX_WIDTH   = (NUM_EGR_PHYS_PORTS > 1) ? $clog2(NUM_EGR_PHYS_PORTS) : 1
) (
    input  logic                          clk,
    input  logic                          aresetn,

    input  logic                          converged_egr_bus_tvalid,
    output logic                          converged_egr_bus_tready,
    input  logic [DATA_BYTES*8-1:0]       converged_egr_bus_tdata,
    input  logic [DATA_BYTES-1:0]         converged_egr_bus_tkeep,
    input  logic [DATA_BYTES-1:0]         converged_egr_bus_tstrb,
    input  logic                          converged_egr_bus_tlast,
    input  logic [ID_WIDTH-1:0]           converged_egr_bus_tid,
    input  logic [DEST_WIDTH-1:0]         converged_egr_bus_tdest,
    input  logic [USER_WIDTH-1:0]         converged_egr_bus_tuser,

    output logic [NUM_EGR_PHYS_PORTS-1:0] egr_phys_ports_tvalid,
    input  logic [NUM_EGR_PHYS_PORTS-1:0] egr_phys_ports_tready,
    output logic [DATA_BYTES*8-1:0]       egr_phys_ports_tdata,
    output logic [DATA_BYTES-1:0]         egr_phys_ports_tkeep,
    output logic [DATA_BYTES-1:0]         egr_phys_ports_tstrb,
    output logic                          egr_phys_ports_tlast,
    output logic [ID_WIDTH-1:0]           egr_phys_ports_tid,
    output logic [DEST_WIDTH-1:0]         egr_phys_ports_tdest,
    output logic [USER_WIDTH-1:0]         egr_phys_ports_tuser,

    input  logic [NUM_EGR_PHYS_PORTS-1:0] egr_port_enable,
    output logic                          drop_pulse,
    output logic [31:0]                   drop_pkt_cnt,
    output logic [31:0]                   fwd_pkt_cnt
);

    localparam int PAD_PORTS = 1 << PORT_INDEX_WIDTH;
    localparam logic [PORT_INDEX_WIDTH:0] NUM_PORTS_W = (PORT_INDEX_WIDTH+1)'(NUM_EGR_PHYS_PORTS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t                      state_r;
    state_t                      state_next_s;

    logic                        out_valid_r;
    logic [PORT_INDEX_WIDTH-1:0] out_sel_r;
    logic [DATA_BYTES*8-1:0]     out_tdata_r;
    logic [DATA_BYTES-1:0]       out_tkeep_r;
    logic [DATA_BYTES-1:0]       out_tstrb_r;
    logic                        out_tlast_r;
    logic [ID_WIDTH-1:0]         out_tid_r;
    logic [DEST_WIDTH-1:0]       out_tdest_r;
    logic [31:0]                 drop_cnt_r;
    logic [31:0]                 fwd_cnt_r;

    logic [PORT_INDEX_WIDTH-1:0] idx_s;
    logic [PAD_PORTS-1:0]        en_pad_s;
    logic [PAD_PORTS-1:0]        rdy_pad_s;
    logic                        idx_ok_s;
    logic                        out_ready_s;
    logic                        in_ready_s;
    logic                        accept_s;
    logic                        load_s;
    logic                        drop_sop_s;
    logic                        fwd_last_s;
    logic [PORT_INDEX_WIDTH-1:0] load_sel_s;
    logic                        unused_s;

    assign unused_s = ^converged_egr_bus_tuser;

    // Zero-extend the per-port vectors so any index value is a safe lookup.
    always_comb begin
        en_pad_s                         = '0;
        rdy_pad_s                        = '0;
        en_pad_s[NUM_EGR_PHYS_PORTS-1:0]  = egr_port_enable;
        rdy_pad_s[NUM_EGR_PHYS_PORTS-1:0] = egr_phys_ports_tready;
    end

    assign idx_s       = converged_egr_bus_tuser[PORT_INDEX_WIDTH-1:0];
    assign idx_ok_s    = ({1'b0, idx_s} < NUM_PORTS_W) && en_pad_s[idx_s];
    assign out_ready_s = !out_valid_r || rdy_pad_s[out_sel_r];

    // Packet FSM next-state and per-beat control decode.
    always_comb begin
        state_next_s = state_r;
        load_s       = 1'b0;
        drop_sop_s   = 1'b0;
        fwd_last_s   = 1'b0;
        in_ready_s   = (state_r == ST_DROP) ? 1'b1 : out_ready_s;
        accept_s     = converged_egr_bus_tvalid && in_ready_s;
        load_sel_s   = (state_r == ST_IDLE) ? idx_s : out_sel_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && idx_ok_s) begin
                    load_s       = 1'b1;
                    fwd_last_s   = converged_egr_bus_tlast;
                    state_next_s = converged_egr_bus_tlast ? ST_IDLE : ST_FWD;
                end else if (accept_s) begin
                    drop_sop_s   = 1'b1;
                    state_next_s = converged_egr_bus_tlast ? ST_IDLE : ST_DROP;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_FWD: begin
                if (accept_s) begin
                    load_s       = 1'b1;
                    fwd_last_s   = converged_egr_bus_tlast;
                    state_next_s = converged_egr_bus_tlast ? ST_IDLE : ST_FWD;
                end else begin
                    state_next_s = ST_FWD;
                end
            end
            ST_DROP: begin
                if (accept_s && converged_egr_bus_tlast) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DROP;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Shared single-stage output register; loading and draining may coincide.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            out_valid_r <= 1'b0;
            out_sel_r   <= '0;
            out_tdata_r <= '0;
            out_tkeep_r <= '0;
            out_tstrb_r <= '0;
            out_tlast_r <= 1'b0;
            out_tid_r   <= '0;
            out_tdest_r <= '0;
        end else if (load_s) begin
            out_valid_r <= 1'b1;
            out_sel_r   <= load_sel_s;
            out_tdata_r <= converged_egr_bus_tdata;
            out_tkeep_r <= converged_egr_bus_tkeep;
            out_tstrb_r <= converged_egr_bus_tstrb;
            out_tlast_r <= converged_egr_bus_tlast;
            out_tid_r   <= converged_egr_bus_tid;
            out_tdest_r <= converged_egr_bus_tdest;
        end else if (out_valid_r && rdy_pad_s[out_sel_r]) begin
            out_valid_r <= 1'b0;
        end
    end

    // Saturating drop and forward packet counters.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            drop_cnt_r <= 32'd0;
            fwd_cnt_r  <= 32'd0;
        end else begin
            if (drop_sop_s && (drop_cnt_r != 32'hFFFF_FFFF)) begin
                drop_cnt_r <= drop_cnt_r + 32'd1;
            end
            if (fwd_last_s && (fwd_cnt_r != 32'hFFFF_FFFF)) begin
                fwd_cnt_r <= fwd_cnt_r + 32'd1;
            end
        end
    end

    // Only the latched port sees tvalid; payload fans out to every port.
    always_comb begin
        egr_phys_ports_tvalid = '0;
        for (int i = 0; i < NUM_EGR_PHYS_PORTS; i++) begin
            egr_phys_ports_tvalid[i] = out_valid_r && (out_sel_r == PORT_INDEX_WIDTH'(i));
        end
    end

    assign converged_egr_bus_tready = in_ready_s;
    assign egr_phys_ports_tdata     = out_tdata_r;
    assign egr_phys_ports_tkeep     = out_tkeep_r;
    assign egr_phys_ports_tstrb     = out_tstrb_r;
    assign egr_phys_ports_tlast     = out_tlast_r;
    assign egr_phys_ports_tid       = out_tid_r;
    assign egr_phys_ports_tdest     = out_tdest_r;
    assign egr_phys_ports_tuser     = '0;
    assign drop_pulse               = drop_sop_s;
    assign drop_pkt_cnt             = drop_cnt_r;
    assign fwd_pkt_cnt              = fwd_cnt_r;

endmodule

// File: tb/tb_mpls_egress_demux.sv
// Self-checking bench for mpls_egress_demux: directed scenarios plus a random
// run scored against a packet-level model of the steering and drop rules.
module tb_mpls_egress_demux;

    localparam int N  = 5;
    localparam int DB = 8;
    localparam int UW = 8;
    localparam int IW = 4;
    localparam int DW = 4;
    localparam int PW = 3;

    logic            clk = 1'b0;
    logic            aresetn;
    logic            in_tvalid;
    logic            conv_tready;
    logic [DB*8-1:0] in_tdata;
    logic [DB-1:0]   in_tkeep;
    logic [DB-1:0]   in_tstrb;
    logic            in_tlast;
    logic [IW-1:0]   in_tid;
    logic [DW-1:0]   in_tdest;
    logic [UW-1:0]   in_tuser;
    logic [N-1:0]    egr_tvalid;
    logic [N-1:0]    egr_tready;
    logic [DB*8-1:0] egr_tdata;
    logic [DB-1:0]   egr_tkeep;
    logic [DB-1:0]   egr_tstrb;
    logic            egr_tlast;
    logic [IW-1:0]   egr_tid;
    logic [DW-1:0]   egr_tdest;
    logic [UW-1:0]   egr_tuser;
    logic [N-1:0]    egr_en;
    logic            drop_pulse;
    logic [31:0]     drop_cnt;
    logic [31:0]     fwd_cnt;

    typedef struct packed {
        logic [2:0]  port;
        logic [63:0] data;
        logic [7:0]  keep;
        logic [7:0]  strb;
        logic        last;
        logic [3:0]  id;
        logic [3:0]  dest;
        logic [31:0] cyc;
    } beat_t;

    int    tests_run    = 0;
    int    tests_failed = 0;
    beat_t exp_q[$];
    beat_t obs_q[$];
    int    cyc = 0;
    int    stab_err = 0;
    int    multi_err = 0;
    int    user_err = 0;
    int    pulse_cnt = 0;
    logic            hold_r = 1'b0;
    logic [N-1:0]    prev_valid = '0;
    logic [DB*8-1:0] prev_data = '0;
    logic [DB-1:0]   prev_keep = '0;
    logic            prev_last = 1'b0;
    bit          rnd_mode = 1'b0;
    bit          m_in_pkt = 1'b0;
    bit          m_fwd = 1'b0;
    logic [2:0]  m_port = 3'd0;
    int          m_fwd_cnt = 0;
    int          m_drop_cnt = 0;

    always #5 clk = ~clk;

    mpls_egress_demux #(
        .NUM_EGR_PHYS_PORTS(N), .DATA_BYTES(DB), .USER_WIDTH(UW), .ID_WIDTH(IW), .DEST_WIDTH(DW)
    ) dut (
        .clk(clk), .aresetn(aresetn),
        .converged_egr_bus_tvalid(in_tvalid), .converged_egr_bus_tready(conv_tready),
        .converged_egr_bus_tdata(in_tdata), .converged_egr_bus_tkeep(in_tkeep),
        .converged_egr_bus_tstrb(in_tstrb), .converged_egr_bus_tlast(in_tlast),
        .converged_egr_bus_tid(in_tid), .converged_egr_bus_tdest(in_tdest),
        .converged_egr_bus_tuser(in_tuser),
        .egr_phys_ports_tvalid(egr_tvalid), .egr_phys_ports_tready(egr_tready),
        .egr_phys_ports_tdata(egr_tdata), .egr_phys_ports_tkeep(egr_tkeep),
        .egr_phys_ports_tstrb(egr_tstrb), .egr_phys_ports_tlast(egr_tlast),
        .egr_phys_ports_tid(egr_tid), .egr_phys_ports_tdest(egr_tdest),
        .egr_phys_ports_tuser(egr_tuser),
        .egr_port_enable(egr_en), .drop_pulse(drop_pulse),
        .drop_pkt_cnt(drop_cnt), .fwd_pkt_cnt(fwd_cnt)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Egress monitor: captures handshaken beats and tallies protocol violations.
    always @(negedge clk) begin
        if (!aresetn) begin
            hold_r <= 1'b0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (egr_tvalid[i] && egr_tready[i])
                    obs_q.push_back('{port: 3'(i), data: egr_tdata, keep: egr_tkeep, strb: egr_tstrb,
                                      last: egr_tlast, id: egr_tid, dest: egr_tdest, cyc: 32'(cyc)});
            end
            if (!$onehot0(egr_tvalid)) multi_err <= multi_err + 1;
            if (egr_tuser !== '0) user_err <= user_err + 1;
            if (hold_r && (egr_tvalid !== prev_valid || egr_tdata !== prev_data ||
                           egr_tkeep !== prev_keep || egr_tlast !== prev_last))
                stab_err <= stab_err + 1;
            hold_r     <= |(egr_tvalid & ~egr_tready);
            prev_valid <= egr_tvalid;
            prev_data  <= egr_tdata;
            prev_keep  <= egr_tkeep;
            prev_last  <= egr_tlast;
            if (drop_pulse) pulse_cnt <= pulse_cnt + 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rnd_mode)
            for (int i = 0; i < N; i++) egr_tready[i] = ($urandom_range(0, 3) != 0);
    endtask

    // Packet-level reference: decision taken once at SOP from index and enable.
    task automatic model_accept();
        int idx;
        if (!m_in_pkt) begin
            idx    = int'(in_tuser[PW-1:0]);
            m_port = in_tuser[PW-1:0];
            m_fwd  = (idx < N) ? bit'(egr_en[idx]) : 1'b0;
            if (!m_fwd) m_drop_cnt++;
        end
        if (m_fwd) begin
            exp_q.push_back('{port: m_port, data: in_tdata, keep: in_tkeep, strb: in_tstrb,
                              last: in_tlast, id: in_tid, dest: in_tdest, cyc: 32'(cyc)});
            if (in_tlast) m_fwd_cnt++;
        end
        m_in_pkt = !in_tlast;
    endtask

    task automatic drive_beat(input logic [UW-1:0] user, input logic last);
        in_tdata  = {$urandom(), $urandom()};
        in_tkeep  = 8'($urandom_range(1, 255));
        in_tstrb  = in_tkeep;
        in_tid    = 4'($urandom);
        in_tdest  = 4'($urandom);
        in_tuser  = user;
        in_tlast  = last;
        in_tvalid = 1'b1;
    endtask

    task automatic wait_accept(input string name, output bit ok);
        bit acc;
        ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            acc = conv_tready;
            if (acc) model_accept();
            step();
            if (acc) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            tests_run++;
            tests_failed++;
            $display("FAIL %s: handshake timeout, converged tready stayed 0, required 1", name);
        end
    endtask

    task automatic send_pkt(input logic [UW-1:0] user, input int nbeats, input int gap_pct,
                            input int chg_beat, input logic [N-1:0] chg_en);
        bit ok;
        for (int b = 0; b < nbeats; b++) begin
            if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
                in_tvalid = 1'b0;
                step();
            end
            if (b == chg_beat) egr_en = chg_en;
            drive_beat((b == 0) ? user : UW'($urandom), b == nbeats - 1);
            wait_accept("send_pkt", ok);
            if (!ok) begin
                in_tvalid = 1'b0;
                return;
            end
        end
        in_tvalid = 1'b0;
    endtask

    task automatic drain_and_compare(input string name, input bit check_lat);
        beat_t e;
        beat_t o;
        rnd_mode   = 1'b0;
        egr_tready = '1;
        in_tvalid  = 1'b0;
        repeat (4) step();
        tests_run++;
        if (obs_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL %s_count: got %0d egress beats, expected %0d", name, obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            tests_run++;
            if ({o.port, o.data, o.keep, o.strb, o.last, o.id, o.dest} !==
                {e.port, e.data, e.keep, e.strb, e.last, e.id, e.dest}) begin
                tests_failed++;
                $display("FAIL %s_beat: got port %0d data %h keep %h last %b, expected port %0d data %h keep %h last %b",
                         name, o.port, o.data, o.keep, o.last, e.port, e.data, e.keep, e.last);
            end
            if (check_lat) begin
                tests_run++;
                if (o.cyc !== e.cyc + 32'd1) begin
                    tests_failed++;
                    $display("FAIL %s_latency: got cycle %0d, expected %0d", name, o.cyc, e.cyc + 32'd1);
                end
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] want);
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic test_reset();
        aresetn = 1'b0; in_tvalid = 1'b0; in_tdata = '0; in_tkeep = '0; in_tstrb = '0;
        in_tlast = 1'b0; in_tid = '0; in_tdest = '0; in_tuser = '0;
        egr_tready = '1; egr_en = '1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check32("reset_tvalid", 32'(egr_tvalid), 32'd0);
        check32("reset_drop_cnt", drop_cnt, 32'd0);
        check32("reset_fwd_cnt", fwd_cnt, 32'd0);
        check32("reset_drop_pulse", 32'(drop_pulse), 32'd0);
        check32("reset_tdata_lo", egr_tdata[31:0], 32'd0);
        check32("reset_conv_tready", 32'(conv_tready), 32'd1);
        @(posedge clk);
        #1 aresetn = 1'b1;
        step();
    endtask

    task automatic test_back_to_back();
        egr_en = '1; egr_tready = '1;
        for (int p = 0; p < 4; p++) send_pkt(UW'(p), 3, 0, -1, '0);
        for (int k = 0; k < exp_q.size(); k++) check32("b2b_no_bubble", exp_q[k].cyc, exp_q[0].cyc + 32'(k));
        drain_and_compare("b2b", 1'b1);
        check32("b2b_fwd_cnt", fwd_cnt, 32'd4);
    endtask

    task automatic test_backpressure();
        logic [DB*8-1:0] held;
        bit ok;
        egr_en = '1; egr_tready = 5'b11011;
        drive_beat(8'd2, 1'b0);
        held = in_tdata;
        @(negedge clk);
        check32("bp_sop_ready", 32'(conv_tready), 32'd1);
        if (conv_tready) model_accept();
        step();
        drive_beat(UW'($urandom), 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check32("bp_conv_tready", 32'(conv_tready), 32'd0);
            check32("bp_tvalid", 32'(egr_tvalid), 32'b00100);
            check32("bp_held_data", egr_tdata[31:0], held[31:0]);
            step();
        end
        egr_tready = '1;
        wait_accept("bp_beat1", ok);
        drive_beat(UW'($urandom), 1'b1);
        wait_accept("bp_beat2", ok);
        in_tvalid = 1'b0;
        drain_and_compare("bp", 1'b0);
    endtask

    task automatic test_drop_range();
        int p0;
        bit ok;
        egr_en = '1; egr_tready = '1;
        p0 = pulse_cnt;
        drive_beat(8'd5, 1'b0);
        @(negedge clk);
        check32("drop_pulse_sop", 32'(drop_pulse), 32'd1);
        check32("drop_cnt_before_edge", drop_cnt, 32'(m_drop_cnt));
        if (conv_tready) model_accept();
        step();
        check32("drop_cnt_after_edge", drop_cnt, 32'(m_drop_cnt));
        for (int b = 1; b < 4; b++) begin
            drive_beat(UW'($urandom), b == 3);
            wait_accept("drop_beat", ok);
        end
        in_tvalid = 1'b0;
        step();
        check32("drop_pulse_cycles", 32'(pulse_cnt - p0), 32'd1);
        check32("drop_no_egress", 32'(obs_q.size()), 32'd0);
        check32("drop_cnt", drop_cnt, 32'(m_drop_cnt));
        send_pkt(8'd0, 2, 0, -1, '0);
        drain_and_compare("drop_then_fwd", 1'b0);
    endtask

    task automatic test_enable_change();
        egr_tready = '1;
        egr_en = 5'b11101;
        send_pkt(8'd1, 4, 0, 2, 5'b11111);
        drain_and_compare("en_late_set", 1'b0);
        check32("en_late_set_drop_cnt", drop_cnt, 32'(m_drop_cnt));
        egr_en = '1;
        send_pkt(8'd3, 4, 0, 2, 5'b10111);
        drain_and_compare("en_late_clear", 1'b0);
        check32("en_late_clear_fwd_cnt", fwd_cnt, 32'(m_fwd_cnt));
    endtask

    task automatic test_reset_mid_packet();
        bit ok;
        egr_en = '1; egr_tready = '1;
        for (int b = 0; b < 2; b++) begin
            drive_beat((b == 0) ? 8'd0 : UW'($urandom), 1'b0);
            wait_accept("rst_mid_beat", ok);
        end
        drive_beat(UW'($urandom), 1'b0);
        #2 aresetn = 1'b0;
        #1;
        check32("rst_mid_tvalid", 32'(egr_tvalid), 32'd0);
        check32("rst_mid_drop_cnt", drop_cnt, 32'd0);
        check32("rst_mid_fwd_cnt", fwd_cnt, 32'd0);
        in_tvalid = 1'b0;
        m_in_pkt = 1'b0; m_fwd_cnt = 0; m_drop_cnt = 0;
        exp_q.delete();
        obs_q.delete();
        repeat (2) @(posedge clk);
        #1 aresetn = 1'b1;
        step();
        send_pkt(8'd0, 1, 0, -1, '0);
        drain_and_compare("rst_after", 1'b0);
        check32("rst_after_fwd_cnt", fwd_cnt, 32'd1);
    endtask

    task automatic test_random();
        int p0;
        int d0;
        int nb;
        int chg;
        p0 = pulse_cnt;
        d0 = m_drop_cnt;
        egr_en = '1;
        rnd_mode = 1'b1;
        for (int n = 0; n < 10000; n++) begin
            if ($urandom_range(0, 7) == 0) egr_en = N'($urandom);
            nb  = $urandom_range(1, 4);
            chg = ($urandom_range(0, 3) == 0) ? $urandom_range(1, nb) : -1;
            send_pkt(UW'($urandom), nb, 10, chg, N'($urandom));
        end
        drain_and_compare("random", 1'b0);
        check32("random_drop_cnt", drop_cnt, 32'(m_drop_cnt));
        check32("random_fwd_cnt", fwd_cnt, 32'(m_fwd_cnt));
        check32("random_drop_pulses", 32'(pulse_cnt - p0), 32'(m_drop_cnt - d0));
        check32("stability_errors", 32'(stab_err), 32'd0);
        check32("multi_tvalid_errors", 32'(multi_err), 32'd0);
        check32("tuser_nonzero_errors", 32'(user_err), 32'd0);
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_drop_range();
        test_enable_change();
        test_reset_mid_packet();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation still running at time limit, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
